// File: rtl/elink_trig_tmr_tx.sv
// Transmit end of the triplicated trigger e-link: input FIFO, align/run sequencer,
// and three independent output registers with per-copy fault injection.
module elink_trig_tmr_tx #(
  parameter int          DEPTH        = 4,
  parameter int          ALIGN_CYCLES = 8,
  parameter logic [11:0] ALIGN_WORD   = 12'hB3C,
  parameter logic [11:0] IDLE_WORD    = 12'h3C5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] data_in,
  input  logic        data_valid,
  output logic        data_ready,
  input  logic        resync,
  input  logic [2:0]  inject_mask,
  input  logic [11:0] inject_pattern,
  output logic [11:0] data_out1,
  output logic [11:0] data_out2,
  output logic [11:0] data_out3,
  output logic        link_up,
  output logic [15:0] sent_count
);

  localparam int          DATA_W     = 12;
  localparam int          AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          CW         = AW + 1;
  localparam logic [7:0]  ALIGN_LAST = 8'(ALIGN_CYCLES - 1);

  typedef enum logic {ST_ALIGN, ST_RUN} state_t;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              rdy_en;
  state_t            state;
  logic [7:0]        align_cnt;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] word_sel;

  function automatic logic [DATA_W-1:0] corrupt(input logic [DATA_W-1:0] word,
                                                input logic en,
                                                input logic [DATA_W-1:0] pattern);
    return en ? (word ^ pattern) : word;
  endfunction

  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);
  assign data_ready = rdy_en & ~full & ~reset;
  assign push       = data_valid & data_ready;
  assign pop        = (state == ST_RUN) & ~resync & ~empty;

  always_comb begin
    word_sel = IDLE_WORD;
    if (resync || state == ST_ALIGN) word_sel = ALIGN_WORD;
    else if (!empty)                 word_sel = mem[rd_ptr];
  end

  // Storage is datapath only; the occupancy count alone decides validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      rdy_en     <= 1'b0;
      state      <= ST_ALIGN;
      align_cnt  <= '0;
      link_up    <= 1'b0;
      sent_count <= '0;
      data_out1  <= '0;
      data_out2  <= '0;
      data_out3  <= '0;
    end else begin
      rdy_en <= 1'b1;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      // The resync edge itself carries the first word of the new alignment sequence.
      if (resync) begin
        link_up <= 1'b0;
        if (ALIGN_LAST == 8'd0) begin
          state     <= ST_RUN;
          align_cnt <= '0;
        end else begin
          state     <= ST_ALIGN;
          align_cnt <= 8'd1;
        end
      end else if (state == ST_ALIGN) begin
        link_up <= 1'b0;
        if (align_cnt == ALIGN_LAST) begin
          state     <= ST_RUN;
          align_cnt <= '0;
        end else begin
          align_cnt <= align_cnt + 8'd1;
        end
      end else begin
        link_up <= 1'b1;
        if (pop) sent_count <= sent_count + 16'd1;
      end

      data_out1 <= corrupt(word_sel, inject_mask[0], inject_pattern);
      data_out2 <= corrupt(word_sel, inject_mask[1], inject_pattern);
      data_out3 <= corrupt(word_sel, inject_mask[2], inject_pattern);
    end
  end

endmodule

// File: doc/elink_trig_tmr_tx.md
# elink_trig_tmr_tx

Transmit end of the triplicated trigger e-link. Accepts 12-bit trigger words over a valid/ready handshake and buffers them in a small FIFO. Drives three independently registered, identical copies of the link word, which the downstream `elink_trig_voter` majority-votes. Handles link alignment after reset and on request, inserts idle words when no data is pending, and provides per-copy fault injection for exercising the voter.

## Interface
- `DEPTH`, 4: FIFO depth in words; power of two, at least 2.
- `ALIGN_CYCLES`, 8: number of consecutive alignment words sent per alignment sequence; range 1..255.
- `ALIGN_WORD`, 12'hB3C: word sent during alignment.
- `IDLE_WORD`, 12'h3C5: word sent in RUN when the FIFO is empty.

- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `data_in` in 12: trigger word from the producer.
- `data_valid` in 1: `data_in` is valid.
- `data_ready` out 1: FIFO can accept; a word transfers on an edge where `data_valid & data_ready`.
- `resync` in 1: single-cycle request to re-run the alignment sequence.
- `inject_mask` in 3: bit i set corrupts copy i+1 for the current output word.
- `inject_pattern` in 12: XOR mask applied to the corrupted copies.
- `data_out1`, `data_out2`, `data_out3` out 12 each: replicated link words, one register per copy.
- `link_up` out 1: high while in RUN.
- `sent_count` out 16: number of FIFO data words transmitted; wraps at 2^16.

## Operation
- The FIFO has `DEPTH` entries with read and write pointers plus an occupancy count.
  - `data_ready` = not full and not in reset.
  - A push and a pop may occur on the same edge; the count is then unchanged.
  - Word order is strictly preserved.
- State machine:
  - ALIGN: each edge, all three copies load `ALIGN_WORD` and the alignment counter increments. After `ALIGN_CYCLES` alignment words have been sent, the next state is RUN. The FIFO still accepts pushes in ALIGN but is never popped.
  - RUN: each edge, if the FIFO is non-empty, pop the head and load it into all three copies, then increment `sent_count`. Otherwise load `IDLE_WORD` and do not increment `sent_count`.
  - `resync` high on an edge, in either state: go to ALIGN, clear the alignment counter, load `ALIGN_WORD`, and do not pop. FIFO contents are preserved. A `resync` during ALIGN restarts the full count.
- Fault injection: on each edge, copy i is loaded with the selected word XOR (`inject_mask[i-1]` ? `inject_pattern` : 0).
  - Applies to alignment, idle and data words alike.
  - Has no effect on FIFO state or `sent_count`.
- The three output registers are separate flops with no shared fan-out register, so they must not be merged.

## Timing
- Reset, sampled on an edge:
  - `data_out1/2/3` = 12'h000.
  - `link_up` = 0.
  - `sent_count` = 0.
  - FIFO emptied.
  - `data_ready` = 0.
  - State = ALIGN with the alignment counter at 0.
  - A reset mid-transfer discards any buffered words.
- First edge after reset deasserts: the outputs become `ALIGN_WORD` and `data_ready` goes to 1.
- `ALIGN_WORD` appears on exactly `ALIGN_CYCLES` consecutive edges (absent `resync`). On the following edge `link_up` = 1 and the outputs show data or idle.
- Latency: a word accepted on edge E into an empty FIFO while in RUN appears on all copies after edge E+1.
- Back-to-back throughput: one word per cycle. With continuous valid, `data_ready` never drops in RUN.
- Full FIFO: `data_ready` = 0 in the same cycle the count reaches `DEPTH`. It returns to 1 on the cycle after a pop.
- `link_up` falls on the edge that samples `resync`, coincident with the first `ALIGN_WORD`.
- `sent_count` updates on the same edge as the corresponding data word is registered, and wraps from 16'hFFFF to 0.

## Test plan
1. Reset for 3 cycles, then idle with `data_valid` = 0. Required: outputs 0 during reset, then 12'hB3C for 8 edges, then 12'h3C5 continuously. `link_up` rises with the first 12'h3C5.
2. In RUN, push 12'h001, 12'h002, 12'h003 back-to-back. Required: each word appears on all copies one edge after acceptance, in order, then 12'h3C5. `sent_count` = 3.
3. Push 6 words during ALIGN with `DEPTH` = 4. Required: `data_ready` drops after the 4th push. The 4 words emerge in order starting on the first RUN edge, and the remaining 2 transfer as space frees.
4. In RUN, send 12'hFFF with `inject_mask` = 3'b001 and `inject_pattern` = 12'hFFF. Required: `data_out1` = 12'h000 and `data_out2`/`data_out3` = 12'hFFF. Verify with the voter attached that it outputs 12'hFFF and flags the disagreement.
5. Assert `resync` while 2 words are buffered. Required: `link_up` = 0 and 8 words of 12'hB3C are sent. The 2 buffered words then follow in order, and `sent_count` counts only those data words.
6. Preload `sent_count` to 16'hFFFE via traffic, then send 3 words. Required: the count wraps to 16'h0001.
